ul_frame_monitor: RTL and testbench
===================================

# ul_frame_monitor

Parametrised uplink frame monitor. It recovers bit timing from the serial uplink line and validates the preamble, start-of-frame delimiter and a length-bearing header. It then deserialises a variable number of payload words and buffers the header and payload words, tagged, in an output FIFO for the UL FEC engine. Compared with the previous monitor it generalises word, header and length widths, and adds abort on enable loss, length checking, FIFO overflow detection and frame/error statistics.

## Interface
- `WORD_W`, 8: payload word width in bits.
- `HDR_W`, 16: header width in bits; `HDR_W >= LEN_W` and `HDR_W >= WORD_W`.
- `LEN_W`, 8: length field width, `header[LEN_W-1:0]`.
- `MAX_WORDS`, 200: maximum legal payload word count.
- `PREAMBLE_COUNT`, 8: number of alternating preamble bits required.
- `DIV_WIDTH`, 8: bit-period divider width.
- `FIFO_AW`, 4: output FIFO address width; depth is `2**FIFO_AW`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `ul_in`, in, 1: serial uplink line, already synchronised.
- `ul_en`, in, 1: monitor enable; deassertion mid-frame aborts the frame.
- `clk_div`, in, DIV_WIDTH: bit period in cycles, minus 1; must be at least 3.
- `rd`, in, 1: FIFO pop; ignored when empty.
- `rd_valid`, out, 1: FIFO not empty.
- `rd_tag`, out, 2: head tag: 0 = header, 1 = data, 2 = last data.
- `rd_data`, out, HDR_W: head payload; data words are zero-extended.
- `level`, out, FIFO_AW+1: FIFO occupancy.
- `busy`, out, 1: state is not IDLE.
- `frame_done`, out, 1: one-cycle pulse when a frame completes.
- `err`, out, 1: one-cycle error pulse.
- `err_code`, out, 2: 1 = preamble/SFD, 2 = length, 3 = abort or overflow; holds its value until the next error.
- `frame_cnt`, out, 16: count of good frames, saturating.
- `err_cnt`, out, 16: count of errors, saturating.

## Operation
- Bit timing:
  - In IDLE with `ul_en` high, a registered 0→1 edge of `ul_in` loads the baud counter with `clk_div>>1`.
  - Each time the counter reaches 0 it produces a sample tick and reloads `clk_div`.
  - A bit is sampled on each tick, so the bit period is `clk_div+1` cycles.
- The first sampled bit is 1 and counts as preamble bit 1.
- States: IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, DONE.
  - IDLE → PREAMBLE on the first edge.
  - PREAMBLE: sampled bits must alternate, starting with 1. A bit that breaks alternation → IDLE with err code 1. After `PREAMBLE_COUNT` bits → SFD.
  - SFD: the next two bits must both be 1.
    - The first SFD bit is checked against the expected 1.
    - A 0 in either SFD bit → IDLE, err code 1.
  - HEADER: shift `HDR_W` bits in, MSB first. Then L = `header[LEN_W-1:0]`.
    - If L > `MAX_WORDS` → IDLE, err code 2, nothing pushed.
    - Otherwise push the header with tag 0 (tag 2 if L = 0, a header-only frame). Then go to PAYLOAD, or to DONE if L = 0.
  - PAYLOAD: shift `WORD_W` bits MSB first per word and push each word. The word count has LEN_W+1 bits. The Lth word gets tag 2, then → DONE.
  - DONE: for one cycle, pulse `frame_done`, increment `frame_cnt`, then → IDLE.
- Push when the FIFO is full:
  - The entry is dropped and `err` pulses with code 3.
  - The frame finishes reception but does not count as good (no `frame_done`).
  - Each frame counts at most one overflow error.
- `ul_en` low in any non-IDLE state:
  - The next cycle is IDLE, with an `err` pulse, code 3.
  - Entries already pushed remain in the FIFO.
- Simultaneous push and `rd`:
  - On a full FIFO the push still overflows; no pop-first bypass.
  - On an empty FIFO only the push takes effect.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values: `rd_valid`=0, `rd_tag`=0, `rd_data`=0, `level`=0, `busy`=0, `frame_done`=0, `err`=0, `err_code`=0, `frame_cnt`=0, `err_cnt`=0. The state is IDLE and the FIFO is empty.
- A push happens 1 cycle after the tick of the word's last bit. `rd_valid` rises on the following cycle.
- `frame_done` is asserted 1 cycle after the push of the last entry.
- Errors: `err` pulses 1 cycle after the detecting tick or the `ul_en` fall. `err_cnt` updates in the same cycle as the pulse.
- `rd_data`/`rd_tag` show the FIFO head combinationally. A pop with `rd` advances the head at the clock edge.
- Reset asserted mid-frame clears everything asynchronously, including FIFO contents.

## Structure
- Shared package `ul_mon_pkg`: tag enum (HDR, DATA, LAST), err_code enum, state enum.
- Sub-module: the existing generic `fifo` (DW = HDR_W+2, AW = FIFO_AW). Bit timing, the FSM and the shifters stay in this block.

## Test plan
- Good frame, clk_div=7, preamble of 8 alternating bits, SFD, header 16'h0003, payload words A5, 3C, FF:
  - FIFO holds {0,0003},{1,A5},{1,3C},{2,FF}.
  - `frame_done` pulses once; `frame_cnt`=1.
- Header 16'h0000: a single entry {2,0000}, and `frame_done` pulses.
- Header length 201 with MAX_WORDS=200: no push; `err` with code 2; `err_cnt`=1.
- Preamble bit 5 inverted: `err` with code 1; state returns to IDLE; a following good frame is received correctly.
- FIFO_AW=2 with `rd` held low and an 8-word frame:
  - 4 entries kept.
  - One overflow `err` (code 3).
  - No `frame_done`.
- `ul_en` dropped in the middle of word 2: `err` code 3 in the next cycle; header and word 1 remain; `busy`=0.

Source files
------------

// File: rtl/ul_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ul_mon_pkg
// Purpose  : Shared types for the uplink frame monitor (FIFO tags, error
//            codes, receive-state encoding) plus a saturating counter helper.
// Revision : 1.0 - initial release
// ============================================================================
package ul_mon_pkg;

  typedef enum logic [1:0] {
    TAG_HDR  = 2'd0,
    TAG_DATA = 2'd1,
    TAG_LAST = 2'd2
  } tag_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_SYNC  = 2'd1,
    ERR_LEN   = 2'd2,
    ERR_ABORT = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_HEADER   = 3'd3,
    ST_PAYLOAD  = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ul_frame_monitor_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fifo
// Purpose  : Generic synchronous FIFO, depth 2**AW, head shown
//            combinationally. Writes to a full FIFO and reads from an empty
//            FIFO are ignored. Reset clears pointers and storage.
// Revision : 1.0 - initial release
// ============================================================================
module fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          w_wr;
  logic          w_rd;

  assign level   = r_wptr - r_rptr;
  assign full    = level[AW];
  assign empty   = (level == '0);
  assign w_wr    = wr_en & ~full;
  assign w_rd    = rd_en & ~empty;
  assign rd_data = r_mem[r_rptr[AW-1:0]];

  // Pointer update and storage write; storage is cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr) begin
        r_mem[r_wptr[AW-1:0]] <= wr_data;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_rd) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ul_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module   : ul_frame_monitor
// Purpose  : Uplink frame monitor. Recovers bit timing from the serial line,
//            checks preamble/SFD, reads a length-bearing header and
//            deserialises payload words into a tagged output FIFO. Reports
//            sync/length/abort/overflow errors and keeps frame statistics.
// Revision : 1.0 - initial release
// ============================================================================
module ul_frame_monitor
  import ul_mon_pkg::*;
#(
  parameter int WORD_W         = 8,
  parameter int HDR_W          = 16,
  parameter int LEN_W          = 8,
  parameter int MAX_WORDS      = 200,
  parameter int PREAMBLE_COUNT = 8,
  parameter int DIV_WIDTH      = 8,
  parameter int FIFO_AW        = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ul_in,
  input  logic                 ul_en,
  input  logic [DIV_WIDTH-1:0] clk_div,
  input  logic                 rd,
  output logic                 rd_valid,
  output logic [1:0]           rd_tag,
  output logic [HDR_W-1:0]     rd_data,
  output logic [FIFO_AW:0]     level,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [15:0]          frame_cnt,
  output logic [15:0]          err_cnt
);

  // Bit counter must cover the longest field: header, word or preamble.
  localparam int BIT_MAX0 = (HDR_W > WORD_W) ? HDR_W : WORD_W;
  localparam int BIT_MAX  = (BIT_MAX0 > PREAMBLE_COUNT) ? BIT_MAX0 : PREAMBLE_COUNT;
  localparam int BC_W     = $clog2(BIT_MAX + 1);
  localparam logic [LEN_W:0] MAX_L = (LEN_W + 1)'(MAX_WORDS);

  state_e                r_state, w_state_n;
  logic                  r_in_q, r_in_qq;
  logic [DIV_WIDTH-1:0]  r_cnt;
  logic [BC_W-1:0]       r_bits, w_bits_n;
  logic [HDR_W-1:0]      r_shift, w_shift_n, w_shifted, w_word_ext;
  logic [LEN_W-1:0]      r_len, w_len_n, w_len_field;
  logic [LEN_W:0]        r_wcnt, w_wcnt_n, w_wcnt_inc;
  logic                  r_exp, w_exp_n;
  logic                  r_push, w_push_n;
  tag_e                  r_push_tag, w_push_tag_n;
  logic [HDR_W-1:0]      r_push_data, w_push_data_n;
  logic                  w_fsm_err;
  err_code_e             w_fsm_code;
  logic                  w_start, w_tick;
  logic                  r_ovf_seen, w_ovf, w_ovf_err, w_err_any, w_good;
  err_code_e             w_err_code;
  logic                  r_err, r_frame_done;
  err_code_e             r_err_code;
  logic [15:0]           r_frame_cnt, r_err_cnt;
  logic                  w_fifo_full, w_fifo_empty;
  logic [HDR_W+1:0]      w_fifo_rd;

  assign w_start     = (r_state == ST_IDLE) && ul_en && r_in_q && !r_in_qq;
  assign w_tick      = (r_state != ST_IDLE) && (r_cnt == '0);
  assign w_shifted   = {r_shift[HDR_W-2:0], r_in_q};
  assign w_len_field = w_shifted[LEN_W-1:0];
  assign w_wcnt_inc  = r_wcnt + (LEN_W + 1)'(1);

  // Zero-extend the freshly completed payload word to the FIFO data width.
  always_comb begin
    w_word_ext               = '0;
    w_word_ext[WORD_W-1:0]   = w_shifted[WORD_W-1:0];
  end

  // Line registers (edge detect, sampled bit) and the baud counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_q  <= 1'b0;
      r_in_qq <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_in_q  <= ul_in;
      r_in_qq <= r_in_q;
      if (w_start) begin
        r_cnt <= clk_div >> 1;
      end else if (r_state != ST_IDLE) begin
        r_cnt <= (r_cnt == '0) ? clk_div : r_cnt - 1'b1;
      end
    end
  end

  // Receive FSM state and field registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_bits      <= '0;
      r_shift     <= '0;
      r_len       <= '0;
      r_wcnt      <= '0;
      r_exp       <= 1'b1;
      r_push      <= 1'b0;
      r_push_tag  <= TAG_HDR;
      r_push_data <= '0;
    end else begin
      r_state     <= w_state_n;
      r_bits      <= w_bits_n;
      r_shift     <= w_shift_n;
      r_len       <= w_len_n;
      r_wcnt      <= w_wcnt_n;
      r_exp       <= w_exp_n;
      r_push      <= w_push_n;
      r_push_tag  <= w_push_tag_n;
      r_push_data <= w_push_data_n;
    end
  end

  // Next-state logic: field checks on each sample tick, abort on enable loss.
  always_comb begin
    w_state_n     = r_state;
    w_bits_n      = r_bits;
    w_shift_n     = r_shift;
    w_len_n       = r_len;
    w_wcnt_n      = r_wcnt;
    w_exp_n       = r_exp;
    w_push_n      = 1'b0;
    w_push_tag_n  = r_push_tag;
    w_push_data_n = r_push_data;
    w_fsm_err     = 1'b0;
    w_fsm_code    = ERR_NONE;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_n = ST_PREAMBLE;
          w_bits_n  = '0;
          w_exp_n   = 1'b1;
        end
      end
      ST_PREAMBLE: begin
        if (w_tick) begin
          if (r_in_q != r_exp) begin
            w_state_n  = ST_IDLE;
            w_fsm_err  = 1'b1;
            w_fsm_code = ERR_SYNC;
          end else begin
            w_exp_n = ~r_exp;
            if (r_bits == BC_W'(PREAMBLE_COUNT - 1)) begin
              w_state_n = ST_SFD;
              w_bits_n  = '0;
            end else begin
              w_bits_n = r_bits + BC_W'(1);
            end
          end
        end
      end
      ST_SFD: begin
        if (w_tick) begin
          if (!r_in_q) begin
            w_state_n  = ST_IDLE;
            w_fsm_err  = 1'b1;
            w_fsm_code = ERR_SYNC;
          end else if (r_bits == BC_W'(1)) begin
            w_state_n = ST_HEADER;
            w_bits_n  = '0;
          end else begin
            w_bits_n = BC_W'(1);
          end
        end
      end
      ST_HEADER: begin
        if (w_tick) begin
          w_shift_n = w_shifted;
          if (r_bits == BC_W'(HDR_W - 1)) begin
            w_bits_n = '0;
            if ({1'b0, w_len_field} > MAX_L) begin
              w_state_n  = ST_IDLE;
              w_fsm_err  = 1'b1;
              w_fsm_code = ERR_LEN;
            end else begin
              w_push_n      = 1'b1;
              w_push_data_n = w_shifted;
              w_push_tag_n  = (w_len_field == '0) ? TAG_LAST : TAG_HDR;
              w_len_n       = w_len_field;
              w_wcnt_n      = '0;
              w_state_n     = (w_len_field == '0) ? ST_DONE : ST_PAYLOAD;
            end
          end else begin
            w_bits_n = r_bits + BC_W'(1);
          end
        end
      end
      ST_PAYLOAD: begin
        if (w_tick) begin
          w_shift_n = w_shifted;
          if (r_bits == BC_W'(WORD_W - 1)) begin
            w_bits_n      = '0;
            w_push_n      = 1'b1;
            w_push_data_n = w_word_ext;
            w_wcnt_n      = w_wcnt_inc;
            if (w_wcnt_inc == {1'b0, r_len}) begin
              w_push_tag_n = TAG_LAST;
              w_state_n    = ST_DONE;
            end else begin
              w_push_tag_n = TAG_DATA;
            end
          end else begin
            w_bits_n = r_bits + BC_W'(1);
          end
        end
      end
      ST_DONE: begin
        w_state_n = ST_IDLE;
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
    if ((r_state != ST_IDLE) && !ul_en) begin
      w_state_n  = ST_IDLE;
      w_push_n   = 1'b0;
      w_fsm_err  = 1'b1;
      w_fsm_code = ERR_ABORT;
    end
  end

  // A push into a full FIFO is lost; only the first such loss per frame is reported.
  assign w_ovf      = r_push && w_fifo_full;
  assign w_ovf_err  = w_ovf && !r_ovf_seen;
  assign w_err_any  = w_fsm_err || w_ovf_err;
  assign w_err_code = w_fsm_err ? w_fsm_code : ERR_ABORT;
  assign w_good     = (r_state == ST_DONE) && ul_en && !r_ovf_seen && !w_ovf;

  // Error/completion pulses, sticky error code and saturating statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_seen   <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_err_cnt    <= '0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      if (w_start) begin
        r_ovf_seen <= 1'b0;
      end else if (w_ovf) begin
        r_ovf_seen <= 1'b1;
      end
      r_err        <= w_err_any;
      r_frame_done <= w_good;
      if (w_err_any) begin
        r_err_code <= w_err_code;
        r_err_cnt  <= sat_inc(r_err_cnt);
      end
      if (w_good) begin
        r_frame_cnt <= sat_inc(r_frame_cnt);
      end
    end
  end

  fifo #(
    .DW (HDR_W + 2),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (r_push),
    .wr_data ({r_push_tag, r_push_data}),
    .rd_en   (rd),
    .rd_data (w_fifo_rd),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty),
    .level   (level)
  );

  assign rd_valid   = !w_fifo_empty;
  assign rd_tag     = w_fifo_rd[HDR_W+1:HDR_W];
  assign rd_data    = w_fifo_rd[HDR_W-1:0];
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = r_frame_done;
  assign err        = r_err;
  assign err_code   = r_err_code;
  assign frame_cnt  = r_frame_cnt;
  assign err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ul_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_ul_frame_monitor
// Purpose  : Self-checking bench: table of directed frames on a 16-deep
//            monitor, plus hand sequences for preamble error, enable abort
//            and FIFO overflow (4-deep monitor).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ul_frame_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ul_en = 1'b1;
  logic [7:0]  clk_div = 8'd7;
  logic        ul_in1 = 1'b0, ul_in2 = 1'b0;
  logic        rd1 = 1'b0, rd2 = 1'b0;

  logic        rd_valid1, busy1, frame_done1, err1;
  logic [1:0]  rd_tag1, err_code1;
  logic [15:0] rd_data1, frame_cnt1, err_cnt1;
  logic [4:0]  level1;

  logic        rd_valid2, busy2, frame_done2, err2;
  logic [1:0]  rd_tag2, err_code2;
  logic [15:0] rd_data2, frame_cnt2, err_cnt2;
  logic [2:0]  level2;

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_seen1 = 0, err_seen1 = 0, done_seen2 = 0, err_seen2 = 0;
  logic [1:0] code_seen1 = 2'd0, code_seen2 = 2'd0;

  always #5 clk = ~clk;

  ul_frame_monitor dut1 (
    .clk(clk), .rst_n(rst_n), .ul_in(ul_in1), .ul_en(ul_en), .clk_div(clk_div),
    .rd(rd1), .rd_valid(rd_valid1), .rd_tag(rd_tag1), .rd_data(rd_data1),
    .level(level1), .busy(busy1), .frame_done(frame_done1), .err(err1),
    .err_code(err_code1), .frame_cnt(frame_cnt1), .err_cnt(err_cnt1)
  );

  ul_frame_monitor #(.FIFO_AW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .ul_in(ul_in2), .ul_en(ul_en), .clk_div(clk_div),
    .rd(rd2), .rd_valid(rd_valid2), .rd_tag(rd_tag2), .rd_data(rd_data2),
    .level(level2), .busy(busy2), .frame_done(frame_done2), .err(err2),
    .err_code(err_code2), .frame_cnt(frame_cnt2), .err_cnt(err_cnt2)
  );

  // Pulse monitors for frame_done / err on both instances.
  always @(negedge clk) begin
    if (frame_done1) done_seen1++;
    if (err1) begin err_seen1++; code_seen1 = err_code1; end
    if (frame_done2) done_seen2++;
    if (err2) begin err_seen2++; code_seen2 = err_code2; end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic set_line(input int which, input logic b);
    if (which == 1) ul_in1 = b;
    else ul_in2 = b;
  endtask

  // Sends n bits MSB first, one bit period (clk_div+1 = 8 cycles) each.
  task automatic send_bits(input logic [63:0] bits, input int n, input int which);
    for (int i = n - 1; i >= 0; i--) begin
      set_line(which, bits[i]);
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic send_frame(input int which, input logic [15:0] hdr, input int nw,
                            input logic [63:0] words);
    logic [63:0] w;
    w = words;
    send_bits(64'b1010101011, 10, which);
    send_bits({48'h0, hdr}, 16, which);
    for (int i = 0; i < nw; i++) send_bits({56'h0, w[63-8*i -: 8]}, 8, which);
    set_line(which, 1'b0);
    repeat (20) @(negedge clk);
  endtask

  // Pops n entries and compares each against the expected frame layout.
  task automatic check_entries(input int which, input logic [15:0] hdr, input int nw,
                               input logic [63:0] words, input int n);
    logic [63:0] w;
    logic [1:0]  etag;
    logic [15:0] edata;
    w = words;
    for (int k = 0; k < n; k++) begin
      if (k == 0) begin
        etag  = (nw == 0) ? 2'd2 : 2'd0;
        edata = hdr;
      end else begin
        etag  = (k == nw) ? 2'd2 : 2'd1;
        edata = {8'h00, w[63-8*(k-1) -: 8]};
      end
      if (which == 1) begin
        check($sformatf("rd_valid1[%0d]", k), rd_valid1, 1);
        check($sformatf("rd_tag1[%0d]", k), rd_tag1, etag);
        check($sformatf("rd_data1[%0d]", k), rd_data1, edata);
        rd1 = 1'b1; @(negedge clk); rd1 = 1'b0;
      end else begin
        check($sformatf("rd_valid2[%0d]", k), rd_valid2, 1);
        check($sformatf("rd_tag2[%0d]", k), rd_tag2, etag);
        check($sformatf("rd_data2[%0d]", k), rd_data2, edata);
        rd2 = 1'b1; @(negedge clk); rd2 = 1'b0;
      end
    end
    if (which == 1) check("rd_valid1 drained", rd_valid1, 0);
    else check("rd_valid2 drained", rd_valid2, 0);
  endtask

  typedef struct {
    logic [15:0] hdr;
    int          nw;
    logic [63:0] words;
    bit          good;
    bit          len_err;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int exp_fc, exp_ec, d0, e0, n_ent;

    vecs[0] = '{16'h0003, 3, 64'hA53CFF00_00000000, 1'b1, 1'b0};
    vecs[1] = '{16'h0000, 0, 64'h0, 1'b1, 1'b0};
    vecs[2] = '{16'h00C9, 0, 64'h0, 1'b0, 1'b1};
    vecs[3] = '{16'hAB01, 1, 64'h5A000000_00000000, 1'b1, 1'b0};
    vecs[4] = '{16'h0002, 2, 64'h00810000_00000000, 1'b1, 1'b0};

    // Reset state
    #2;
    check("rst rd_valid", rd_valid1, 0);
    check("rst rd_tag", rd_tag1, 0);
    check("rst rd_data", rd_data1, 0);
    check("rst level", level1, 0);
    check("rst busy", busy1, 0);
    check("rst frame_done", frame_done1, 0);
    check("rst err", err1, 0);
    check("rst err_code", err_code1, 0);
    check("rst frame_cnt", frame_cnt1, 0);
    check("rst err_cnt", err_cnt1, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    exp_fc = 0;
    exp_ec = 0;

    // Table-driven frames
    for (int v = 0; v < 5; v++) begin
      d0 = done_seen1;
      e0 = err_seen1;
      if (vecs[v].len_err) begin
        send_bits(64'b1010101011, 10, 1);
        send_bits({48'h0, vecs[v].hdr}, 16, 1);
        ul_in1 = 1'b0;
        repeat (20) @(negedge clk);
      end else begin
        send_frame(1, vecs[v].hdr, vecs[v].nw, vecs[v].words);
      end
      if (vecs[v].good) exp_fc++;
      if (vecs[v].len_err) exp_ec++;
      n_ent = vecs[v].good ? vecs[v].nw + 1 : 0;
      check($sformatf("v%0d busy", v), busy1, 0);
      check($sformatf("v%0d level", v), level1, n_ent);
      check($sformatf("v%0d done pulses", v), done_seen1 - d0, vecs[v].good ? 1 : 0);
      check($sformatf("v%0d err pulses", v), err_seen1 - e0, vecs[v].len_err ? 1 : 0);
      if (vecs[v].len_err) check($sformatf("v%0d err_code", v), code_seen1, 2);
      check($sformatf("v%0d frame_cnt", v), frame_cnt1, exp_fc);
      check($sformatf("v%0d err_cnt", v), err_cnt1, exp_ec);
      check_entries(1, vecs[v].hdr, vecs[v].nw, vecs[v].words, n_ent);
    end

    // Preamble bit 5 inverted, then a good frame
    e0 = err_seen1;
    send_bits(64'b10100, 5, 1);
    ul_in1 = 1'b0;
    repeat (20) @(negedge clk);
    exp_ec++;
    check("pre err pulses", err_seen1 - e0, 1);
    check("pre err_code", code_seen1, 1);
    check("pre busy", busy1, 0);
    check("pre level", level1, 0);
    check("pre err_cnt", err_cnt1, exp_ec);
    d0 = done_seen1;
    send_frame(1, vecs[0].hdr, vecs[0].nw, vecs[0].words);
    exp_fc++;
    check("pre+good done", done_seen1 - d0, 1);
    check("pre+good frame_cnt", frame_cnt1, exp_fc);
    check_entries(1, vecs[0].hdr, vecs[0].nw, vecs[0].words, 4);

    // Enable dropped in the middle of payload word 2
    send_bits(64'b1010101011, 10, 1);
    send_bits(64'h0004, 16, 1);
    send_bits(64'h11, 8, 1);
    send_bits(64'b0010, 4, 1);
    check("abort busy before", busy1, 1);
    ul_en = 1'b0;
    @(negedge clk);
    exp_ec++;
    check("abort err", err1, 1);
    check("abort err_code", err_code1, 3);
    check("abort busy", busy1, 0);
    ul_in1 = 1'b0;
    ul_en = 1'b1;
    @(negedge clk);
    check("abort err one cycle", err1, 0);
    repeat (10) @(negedge clk);
    check("abort err_cnt", err_cnt1, exp_ec);
    check("abort frame_cnt", frame_cnt1, exp_fc);
    check("abort level", level1, 2);
    check_entries(1, 16'h0004, 4, 64'h11220000_00000000, 2);

    // Overflow on the 4-deep instance, 8-word frame, no reads
    send_frame(2, 16'h0008, 8, 64'h01020304_05060708);
    check("ovf level", level2, 4);
    check("ovf err pulses", err_seen2, 1);
    check("ovf err_code", code_seen2, 3);
    check("ovf done pulses", done_seen2, 0);
    check("ovf frame_cnt", frame_cnt2, 0);
    check("ovf err_cnt", err_cnt2, 1);
    check_entries(2, 16'h0008, 8, 64'h01020304_05060708, 4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
